count_checker: RTL and testbench

- Receive-side companion to the free-running counter: samples a count stream and checks that each valid sample equals the previous one plus 1, modulo 2^COUNT_W.
- Acquires lock after LOCK_N consecutive correct increments.
- While locked, flags every discontinuity and keeps a saturating error tally.
- Used on the far side of a clock/CDC or link path to prove count integrity in simulation and in silicon.

---
 rtl/count_checker_if.sv | 23 ++
 rtl/count_checker.sv | 98 +++++++++
 tb/tb_count_checker.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/count_checker_if.sv
// Sample stream into the count checker and its lock/error status back out.
interface count_checker_if #(
  parameter int COUNT_W = 32,
  parameter int ERR_W   = 16
);
  logic               i_valid;
  logic [COUNT_W-1:0] i_count;
  logic               i_clear;
  logic               o_locked;
  logic               o_error;
  logic [COUNT_W-1:0] o_expected;
  logic [ERR_W-1:0]   o_err_count;

  modport master (
    output i_valid, i_count, i_clear,
    input  o_locked, o_error, o_expected, o_err_count
  );

  modport slave (
    input  i_valid, i_count, i_clear,
    output o_locked, o_error, o_expected, o_err_count
  );
endinterface

// File: rtl/count_checker.sv
// Checks that a received count stream increments by one per valid sample,
// locks after LOCK_N good increments and tallies discontinuities while locked.
module count_checker #(
  parameter int COUNT_W = 32,
  parameter int ERR_W   = 16,
  parameter int LOCK_N  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  count_checker_if.slave  bus
);

  localparam int RUN_W = $clog2(LOCK_N + 1);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state_q,    state_d;
  logic               seeded_q,   seeded_d;
  logic [RUN_W-1:0]   run_q,      run_d;
  logic [COUNT_W-1:0] expected_q, expected_d;
  logic               error_q,    error_d;
  logic [ERR_W-1:0]   err_cnt_q,  err_cnt_d;

  logic match;
  logic err_hit;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (v == {ERR_W{1'b1}}) return v;
    return v + ERR_W'(1);
  endfunction

  assign match = seeded_q && (bus.i_count == expected_q);

  always_comb begin
    state_d    = state_q;
    seeded_d   = seeded_q;
    run_d      = run_q;
    expected_d = expected_q;
    error_d    = 1'b0;
    err_hit    = 1'b0;

    if (bus.i_valid) begin
      // Always re-seed from the newest sample, good or bad.
      expected_d = bus.i_count + COUNT_W'(1);
      seeded_d   = 1'b1;
      unique case (state_q)
        UNLOCKED: begin
          if (!seeded_q) begin
            run_d = '0;
          end else if (match) begin
            run_d = run_q + RUN_W'(1);
            if (run_d == RUN_W'(LOCK_N)) state_d = LOCKED;
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            error_d = 1'b1;
            err_hit = 1'b1;
            state_d = UNLOCKED;
            run_d   = '0;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end

    // A clear coinciding with an error still keeps that error.
    if (bus.i_clear)  err_cnt_d = err_hit ? ERR_W'(1) : '0;
    else if (err_hit) err_cnt_d = sat_inc(err_cnt_q);
    else              err_cnt_d = err_cnt_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= UNLOCKED;
      seeded_q   <= 1'b0;
      run_q      <= '0;
      expected_q <= '0;
      error_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      seeded_q   <= seeded_d;
      run_q      <= run_d;
      expected_q <= expected_d;
      error_q    <= error_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.o_locked    = (state_q == LOCKED);
  assign bus.o_error     = error_q;
  assign bus.o_expected  = expected_q;
  assign bus.o_err_count = err_cnt_q;

endmodule

// File: tb/tb_count_checker.sv
// Drives two checker instances (8-bit/LOCK_N=4/ERR_W=2 and 32-bit/LOCK_N=1)
// from one stream and compares every cycle against a stream-level reference.
module tb_count_checker;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  count_checker_if #(.COUNT_W(8),  .ERR_W(2))  if_a ();
  count_checker_if #(.COUNT_W(32), .ERR_W(16)) if_b ();

  count_checker #(.COUNT_W(8), .ERR_W(2), .LOCK_N(4)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .bus(if_a)
  );
  count_checker #(.COUNT_W(32), .ERR_W(16), .LOCK_N(1)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .bus(if_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Reference: index 0 models instance A, index 1 models instance B.
  logic [31:0] m_last   [2];
  bit          m_have   [2];
  int          m_streak [2];
  bit          m_locked [2];
  bit          m_pulse  [2];
  int          m_errs   [2];
  logic [31:0] m_next   [2];

  function automatic logic [31:0] mask_of(input int k);
    return (k == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction
  function automatic int lockn_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction
  function automatic int errmax_of(input int k);
    return (k == 0) ? 3 : 65535;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 0; m_have[k] = 0; m_streak[k] = 0; m_locked[k] = 0;
      m_pulse[k] = 0; m_errs[k] = 0; m_next[k] = 0;
    end
  endtask

  task automatic model_sample(input bit v, input logic [31:0] c_raw, input bit clr);
    for (int k = 0; k < 2; k++) begin
      logic [31:0] c;
      bit ok, counted;
      c = c_raw & mask_of(k);
      ok = m_have[k] && (c == ((m_last[k] + 1) & mask_of(k)));
      counted = 0;
      m_pulse[k] = 0;
      if (v) begin
        if (m_locked[k]) begin
          if (!ok) begin
            m_pulse[k] = 1; counted = 1; m_locked[k] = 0; m_streak[k] = 0;
          end
        end else if (ok) begin
          m_streak[k]++;
          if (m_streak[k] == lockn_of(k)) m_locked[k] = 1;
        end else begin
          m_streak[k] = 0;
        end
        m_have[k] = 1;
        m_last[k] = c;
        m_next[k] = (c + 1) & mask_of(k);
      end
      if (clr) m_errs[k] = counted ? 1 : 0;
      else if (counted && m_errs[k] < errmax_of(k)) m_errs[k]++;
    end
  endtask

  task automatic check_all();
    chk("A.locked",  {31'd0, if_a.o_locked},   {31'd0, m_locked[0]});
    chk("A.error",   {31'd0, if_a.o_error},    {31'd0, m_pulse[0]});
    chk("A.expected", {24'd0, if_a.o_expected}, m_next[0]);
    chk("A.errcnt",  {30'd0, if_a.o_err_count}, m_errs[0]);
    chk("B.locked",  {31'd0, if_b.o_locked},   {31'd0, m_locked[1]});
    chk("B.error",   {31'd0, if_b.o_error},    {31'd0, m_pulse[1]});
    chk("B.expected", if_b.o_expected,          m_next[1]);
    chk("B.errcnt",  {16'd0, if_b.o_err_count}, m_errs[1]);
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input bit v, input logic [31:0] c, input bit clr);
    if_a.i_valid = v; if_a.i_count = c[7:0]; if_a.i_clear = clr;
    if_b.i_valid = v; if_b.i_count = c;      if_b.i_clear = clr;
    @(posedge i_clk);
    model_sample(v, c, clr);
    @(negedge i_clk);
    check_all();
  endtask

  task automatic run(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) step(1'b1, first + 32'(i), 1'b0);
  endtask

  task automatic do_reset();
    #2 i_rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] cur;
    if_a.i_valid = 0; if_a.i_count = '0; if_a.i_clear = 0;
    if_b.i_valid = 0; if_b.i_count = '0; if_b.i_clear = 0;
    model_reset();
    @(negedge i_clk);
    do_reset();

    // Lock acquisition on 10..14.
    step(1, 10, 0);
    step(1, 11, 0);
    chk("B.lock_n1", {31'd0, if_b.o_locked}, 32'd1);
    run(12, 3);
    chk("tp1.locked", {31'd0, if_a.o_locked}, 32'd1);
    chk("tp1.expected", {24'd0, if_a.o_expected}, 32'd15);

    // Injected discontinuity and relock.
    run(15, 5);
    step(1, 100, 0);
    chk("tp2.error", {31'd0, if_a.o_error}, 32'd1);
    chk("tp2.errcnt", {30'd0, if_a.o_err_count}, 32'd1);
    chk("tp2.unlocked", {31'd0, if_a.o_locked}, 32'd0);
    run(101, 3);
    chk("tp2.not_yet", {31'd0, if_a.o_locked}, 32'd0);
    step(1, 104, 0);
    chk("tp2.relock", {31'd0, if_a.o_locked}, 32'd1);

    // Wrap across 255 -> 0 on the 8-bit instance.
    run(250, 5);
    run(255, 1);
    run(0, 3);
    chk("tp3.locked", {31'd0, if_a.o_locked}, 32'd1);
    chk("tp3.expected", {24'd0, if_a.o_expected}, 32'd3);

    // Gaps in valid.
    run(3, 4);
    for (int i = 0; i < 3; i++) step(0, 32'(i), 0);
    step(1, 7, 0);
    chk("tp4.gap_ok", {31'd0, if_a.o_error}, 32'd0);
    step(1, 8, 0);
    for (int i = 0; i < 3; i++) step(0, 32'(i), 0);
    step(1, 10, 0);
    chk("tp4.gap_err", {31'd0, if_a.o_error}, 32'd1);

    // Saturation then clear coincident with an error.
    step(0, 0, 1);
    step(1, 20, 0);
    v = 20;
    for (int k = 0; k < 4; k++) begin
      run(v + 1, 4);
      v = v + 34;
      step(1, v, 0);
    end
    chk("tp5.sat", {30'd0, if_a.o_err_count}, 32'd3);
    run(v + 1, 4);
    step(1, 190, 1);
    chk("tp5.clear_err", {30'd0, if_a.o_err_count}, 32'd1);

    // Async reset while locked with two errors counted.
    step(0, 0, 1);
    run(191, 4);
    step(1, 220, 0);
    run(221, 4);
    step(1, 5, 0);
    run(6, 4);
    chk("tp6.pre_cnt", {30'd0, if_a.o_err_count}, 32'd2);
    chk("tp6.pre_lock", {31'd0, if_a.o_locked}, 32'd1);
    do_reset();
    chk("tp6.rst_lock", {31'd0, if_a.o_locked}, 32'd0);
    chk("tp6.rst_cnt", {30'd0, if_a.o_err_count}, 32'd0);
    step(1, 77, 0);
    chk("tp6.seed_err", {31'd0, if_a.o_error}, 32'd0);
    run(78, 3);
    chk("tp6.not_yet", {31'd0, if_a.o_locked}, 32'd0);
    step(1, 81, 0);
    chk("tp6.relock", {31'd0, if_a.o_locked}, 32'd1);

    // Randomized stream: mostly increments, occasional jumps, gaps, clears, resets.
    cur = $urandom;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 3) == 0) begin
        step(0, $urandom, ($urandom_range(0, 31) == 0));
      end else begin
        if ($urandom_range(0, 15) == 0) cur = $urandom;
        else cur = cur + 1;
        step(1, cur, ($urandom_range(0, 31) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
